md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller that time-shares the existing 32-bit combinational ALU.
- Performs 32-bit unsigned shift-add multiply and restoring divide.
- Drives ALU op_A/op_B/ctrl each cycle and registers res/carry.
- Sits beside the single-cycle datapath's ALU. The core stalls on in_ready/out_valid.

Parameters:
- DATA_W, 32: operand width; must equal ALU width.
- CNT_W, 5: iteration counter width; 2**CNT_W == DATA_W.
- ALU_ADD, 4'b0010: ALU ctrl code for add.
- ALU_SUB, 4'b0110: ALU ctrl code for subtract (carry=1 means no borrow).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_op  in  3  000 MUL(low), 001 MULHU, 010 DIVU, 011 REMU, 100 DIV, 101 REM, others reserved
- in_a  in  32  multiplicand/dividend
- in_b  in  32  multiplier/divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_res  out  32  result
- out_div0  out  1  divisor was zero
- alu_a  out  32  to ALU op_A
- alu_b  out  32  to ALU op_B
- alu_ctrl  out  4  to ALU ctrl
- alu_res  in  32  from ALU res
- alu_carry  in  1  from ALU carry

Behaviour:
- One clock; reset is synchronous and active-high. Reset aborts any operation.
- After reset: state IDLE, in_ready=1, out_valid=0, out_res=0, out_div0=0, counter=0.
- ALU drive when no iteration is running: alu_a=0, alu_b=0, alu_ctrl=ALU_ADD.
- States: IDLE, RUN, DONE. With the optional feature, also NEG_A, NEG_B, FIX.
- Accept: in_valid & in_ready at edge E0 latches the op and operands and loads counter=31.
- Next state after accept:
  - Divide op with in_b==0: DONE. Quotient=0xFFFFFFFF, remainder=in_a, out_div0=1; out_valid rises after E1.
  - Any other op: RUN.
- MUL/MULHU, RUN step (registers hi, lo, mcand):
  - alu_a=hi, alu_b=mcand, ALU_ADD.
  - If lo[0]: {hi,lo} <= {carry,res,lo[31:1]}.
  - Else: {hi,lo} <= {1'b0,hi,lo[31:1]}.
- DIVU/REMU, RUN step (registers rem, quo, dvsr):
  - Shifted value t = {rem[30:0],quo[31]}; msb = rem[31].
  - alu_a=t, alu_b=dvsr, ALU_SUB.
  - If msb | carry: rem <= res and quo <= {quo[30:0],1}.
  - Else: rem <= t and quo <= {quo[30:0],0}.
- Counter decrements each RUN cycle. RUN→DONE on the step with counter==0: exactly 32 steps, out_valid high after E33.
- Result select: MUL=lo, MULHU=hi, DIVU=quo, REMU=rem.
- Reserved op: DONE after E1 with out_res=0, out_div0=0.
- DONE: out_valid=1, out_res/out_div0 stable until out_valid & out_ready; then IDLE next cycle.
  - in_ready stays 0 in DONE.
  - No new accept in the same cycle as the output handshake.
- in_valid while busy is ignored. Inputs are not sampled outside IDLE.
- Arithmetic is modulo 2^32. Carry is used only as described; ALU overflow/zero are unused.

Optional Feature:
- Macro MD_SIGNED_EN.
- Defined:
  - DIV/REM are legal.
  - NEG_A negates a if in_a[31] (ALU_SUB 0-a, one cycle, always visited).
  - NEG_B does the same for b.
  - After RUN, FIX negates quo if sign_a^sign_b (DIV), or negates rem if sign_a (REM).
  - Latency 36 cycles.
  - -2^31/-1 gives quo 0x80000000, rem 0.
  - Divisor zero bypasses all negation: quo=-1, rem=a.
- Undefined: codes 100/101 are reserved (result 0). No extra states.

Decomposition:
- Shared include md_defs.vh holds op codes, ALU_ADD/ALU_SUB, and state encodings; the core decoder reuses them.
- One natural sub-module: md_step_counter (CNT_W down counter: load, dec, last flag).

Test Plan:
- MUL 7×6 → out_res=42 (0x2A) after E33; then MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MUL same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; each with out_div0=0.
- DIVU 5/0 → 0xFFFFFFFF, out_div0=1, out_valid after E1; REMU 5/0 → 5.
- Hold out_ready=0 for 10 cycles in DONE → out_res stable, in_ready=0, extra in_valid ignored; on release, IDLE next cycle.
- Assert rst at RUN step 16 → next cycle in_ready=1, out_valid=0; next MUL 3×3 → 9.
- With MD_SIGNED_EN: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIV 0x80000000/-1 → 0x80000000; latency 36.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared constants, op codes, state encodings and decode helpers for md_sequencer.
// Optional signed divide support is enabled with `define MD_SIGNED_EN.
package md_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_REM   = 3'b101;

`ifdef MD_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DONE  = 3'd2,
        S_NEG_A = 3'd3,
        S_NEG_B = 3'd4,
        S_FIX   = 3'd5
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
`endif

    function automatic logic is_div_op(input logic [2:0] op);
        logic r;
        r = (op == OP_DIVU) || (op == OP_REMU);
`ifdef MD_SIGNED_EN
        r = r || (op == OP_DIV) || (op == OP_REM);
`endif
        return r;
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_REMU) || is_div_op(op);
    endfunction

    // hi doubles as the remainder and lo as the quotient during a divide.
    function automatic logic [DATA_W-1:0] sel_result(input logic [2:0]        op,
                                                      input logic [DATA_W-1:0] hi,
                                                      input logic [DATA_W-1:0] lo);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_MUL, OP_DIVU:  r = lo;
            OP_MULHU, OP_REMU: r = hi;
`ifdef MD_SIGNED_EN
            OP_DIV:           r = lo;
            OP_REM:           r = hi;
`endif
            default:          r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Request/response handshake bundle between the core and md_sequencer.
// master = core side issuing requests, slave = sequencer.
interface md_sequencer_if;

    logic                                   in_valid;
    logic                                   in_ready;
    logic [2:0]                             in_op;
    logic [md_sequencer_pkg::DATA_W-1:0]    in_a;
    logic [md_sequencer_pkg::DATA_W-1:0]    in_b;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [md_sequencer_pkg::DATA_W-1:0]    out_res;
    logic                                   out_div0;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_div0
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_div0
    );

endinterface

// File: rtl/md_step_counter.sv
// Iteration down-counter: load to all-ones, decrement per step, flag the final step.
module md_step_counter #(
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '1;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide controller time-sharing the core ALU.
// `define MD_SIGNED_EN adds signed DIV/REM via NEG_A, NEG_B and FIX states.
module md_sequencer
    import md_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    md_sequencer_if.slave     bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_carry
);

    state_e            state;
    logic [2:0]        op;
    logic [DATA_W-1:0] hi;    // product high half / partial remainder
    logic [DATA_W-1:0] lo;    // multiplier shifting out / quotient shifting in
    logic [DATA_W-1:0] opnd;  // multiplicand / divisor
    logic              div0;
    logic              out_valid;
    logic [DATA_W-1:0] out_res;
    logic              out_div0;
    logic              last;
    logic              accept;
    logic [DATA_W-1:0] shifted;
    logic              take;
`ifdef MD_SIGNED_EN
    logic              sign_a;
    logic              sign_b;
    logic              in_signed;
`endif

    assign accept       = (state == S_IDLE) && bus.in_valid;
    assign bus.in_ready = (state == S_IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_res   = out_res;
    assign bus.out_div0  = out_div0;

    // Restoring-divide trial: 33-bit shifted remainder, msb folded in with the no-borrow carry.
    assign shifted = {hi[DATA_W-2:0], lo[DATA_W-1]};
    assign take    = hi[DATA_W-1] | alu_carry;

`ifdef MD_SIGNED_EN
    assign in_signed = (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);
`endif

    md_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .dec  (state == S_RUN),
        .last (last)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        case (state)
            S_RUN: begin
                if (is_div_op(op)) begin
                    alu_a    = shifted;
                    alu_b    = opnd;
                    alu_ctrl = ALU_SUB;
                end else begin
                    alu_a = hi;
                    alu_b = opnd;
                end
            end
`ifdef MD_SIGNED_EN
            S_NEG_A: begin
                alu_b    = lo;
                alu_ctrl = ALU_SUB;
            end
            S_NEG_B: begin
                alu_b    = opnd;
                alu_ctrl = ALU_SUB;
            end
            S_FIX: begin
                alu_b    = (op == OP_DIV) ? lo : hi;
                alu_ctrl = ALU_SUB;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            div0      <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_div0  <= 1'b0;
`ifdef MD_SIGNED_EN
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op   <= bus.in_op;
                        hi   <= '0;
                        div0 <= 1'b0;
                        if (is_div_op(bus.in_op)) begin
                            lo   <= bus.in_a;
                            opnd <= bus.in_b;
                        end else begin
                            lo   <= bus.in_b;
                            opnd <= bus.in_a;
                        end
`ifdef MD_SIGNED_EN
                        sign_a <= in_signed & bus.in_a[DATA_W-1];
                        sign_b <= in_signed & bus.in_b[DATA_W-1];
`endif
                        if (!is_legal_op(bus.in_op)) begin
                            state <= S_DONE;
                        end else if (is_div_op(bus.in_op) && (bus.in_b == '0)) begin
                            hi    <= bus.in_a;
                            lo    <= '1;
                            div0  <= 1'b1;
                            state <= S_DONE;
`ifdef MD_SIGNED_EN
                        end else if (in_signed) begin
                            state <= S_NEG_A;
`endif
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (is_div_op(op)) begin
                        if (take) begin
                            hi <= alu_res;
                            lo <= {lo[DATA_W-2:0], 1'b1};
                        end else begin
                            hi <= shifted;
                            lo <= {lo[DATA_W-2:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        {hi, lo} <= {alu_carry, alu_res, lo[DATA_W-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[DATA_W-1:1]};
                    end
                    if (last) begin
`ifdef MD_SIGNED_EN
                        state <= ((op == OP_DIV) || (op == OP_REM)) ? S_FIX : S_DONE;
`else
                        state <= S_DONE;
`endif
                    end
                end

`ifdef MD_SIGNED_EN
                S_NEG_A: begin
                    if (sign_a) lo <= alu_res;
                    state <= S_NEG_B;
                end

                S_NEG_B: begin
                    if (sign_b) opnd <= alu_res;
                    state <= S_RUN;
                end

                S_FIX: begin
                    if ((op == OP_DIV) && (sign_a ^ sign_b)) lo <= alu_res;
                    if ((op == OP_REM) && sign_a)            hi <= alu_res;
                    state <= S_DONE;
                end
`endif

                S_DONE: begin
                    // First DONE cycle registers the result; out_valid rises with it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_res   <= sel_result(op, hi, lo);
                        out_div0  <= div0;
                    end else if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed, table-driven bench for md_sequencer with a behavioural model of the shared ALU.
// Define MD_SIGNED_EN for both bench and RTL to exercise the signed divide vectors.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        div0;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_carry;

    md_sequencer_if bus ();

    md_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_carry (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's combinational ALU.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        if (alu_ctrl == 4'b0110)
            {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else if (alu_ctrl == 4'b0010)
            {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic add_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic div0,
                           input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.div0 = div0; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Presents a request at the next negedge; returns #1 after the accepting edge E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts edges after E0 until out_valid is seen, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        add_vec("mul_7x6",        OP_MULHU - 3'd1, 32'd7, 32'd6, 32'h0000_002A, 1'b0, 33);
        add_vec("mulhu_max",      OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        add_vec("mul_max",        OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        add_vec("divu_100_7",     OP_DIVU,  32'd100, 32'd7, 32'd14, 1'b0, 33);
        add_vec("remu_100_7",     OP_REMU,  32'd100, 32'd7, 32'd2, 1'b0, 33);
        add_vec("divu_max_1",     OP_DIVU,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        add_vec("divu_msb_3",     OP_DIVU,  32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 1'b0, 33);
        add_vec("remu_msb_3",     OP_REMU,  32'h8000_0000, 32'd3, 32'd2, 1'b0, 33);
        add_vec("divu_max_max",   OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
        add_vec("remu_7_max",     OP_REMU,  32'd7, 32'hFFFF_FFFF, 32'd7, 1'b0, 33);
        add_vec("divu_5_0",       OP_DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        add_vec("remu_5_0",       OP_REMU,  32'd5, 32'd0, 32'd5, 1'b1, 1);
        add_vec("reserved_110",   3'b110,   32'd9, 32'd0, 32'd0, 1'b0, 1);
`ifdef MD_SIGNED_EN
        add_vec("div_m7_2",       OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 36);
        add_vec("rem_m7_2",       OP_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 36);
        add_vec("div_min_m1",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 36);
        add_vec("rem_min_m1",     OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 36);
        add_vec("div_m5_0",       OP_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
`else
        add_vec("reserved_div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1);
        add_vec("reserved_rem",   OP_REM,   32'hFFFF_FFF9, 32'd0, 32'd0, 1'b0, 1);
`endif

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_res",   bus.out_res,            32'd0);
        check("rst_out_div0",  {31'd0, bus.out_div0},  32'd0);
        check("rst_alu_a",     alu_a,                  32'd0);
        check("rst_alu_ctrl",  {28'd0, alu_ctrl},      32'h2);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check({vecs[i].name, "_lat"},  lat,                   vecs[i].lat);
            check({vecs[i].name, "_res"},  bus.out_res,           vecs[i].res);
            check({vecs[i].name, "_div0"}, {31'd0, bus.out_div0}, {31'd0, vecs[i].div0});
            take();
            check({vecs[i].name, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
        end

        // Back-pressure: result held, busy, stray requests ignored.
        issue(OP_MUL, 32'd7, 32'd6);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_op    = OP_MULHU;
            bus.in_a     = 32'd1;
            bus.in_b     = 32'd1;
            @(posedge clk);
            #1;
            check("hold_res",      bus.out_res,            32'h2A);
            check("hold_in_ready", {31'd0, bus.in_ready},  32'd0);
            check("hold_valid",    {31'd0, bus.out_valid}, 32'd1);
        end
        check("hold_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1 check("release_still_idle", {31'd0, bus.in_ready}, 32'd1);

        // Reset in the middle of a multiply.
        issue(OP_MUL, 32'h1234_5678, 32'd3);
        check("run_alu_b",    alu_b,             32'h1234_5678);
        check("run_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("run_busy",     {31'd0, bus.in_ready}, 32'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out_res",   bus.out_res,            32'd0);
        check("midrst_alu_b",     alu_b,                  32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MUL, 32'd3, 32'd3);
        wait_valid(lat);
        check("post_rst_lat", lat,         33);
        check("post_rst_res", bus.out_res, 32'd9);
        take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
